// File: rtl/result_frame_tx_if.sv
// Result-set capture and UART byte-stream handshake bundle for result_frame_tx.
interface result_frame_tx_if #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_RESULTS = 4
);
    logic [NUM_RESULTS*DATA_W-1:0] res_data;
    logic                          res_valid;
    logic                          res_ready;
    logic [7:0]                    tx_data;
    logic                          tx_valid;
    logic                          tx_ack;
    logic                          busy;
    logic                          frame_done;

    modport master (
        output res_data, res_valid, tx_ack,
        input  res_ready, tx_data, tx_valid, busy, frame_done
    );

    modport slave (
        input  res_data, res_valid, tx_ack,
        output res_ready, tx_data, tx_valid, busy, frame_done
    );
endinterface

// File: rtl/result_frame_tx.sv
// Captures one result set and serialises it as SOF, payload bytes (MSB first), EOF.
// Optional XOR checksum byte before EOF when RESULT_FRAME_CSUM_EN is defined.
module result_frame_tx #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_RESULTS = 4,
    parameter logic [7:0]  SOF_BYTE    = 8'hFE,
    parameter logic [7:0]  EOF_BYTE    = 8'hFF
) (
    input  logic              CLK,
    input  logic              RESET,
    result_frame_tx_if.slave  bus
);
    localparam int unsigned BPW       = DATA_W / 8;
    localparam int unsigned NUM_BYTES = NUM_RESULTS * BPW;
    localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);
    localparam int unsigned BUF_W     = NUM_RESULTS * DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_PAYLOAD,
`ifdef RESULT_FRAME_CSUM_EN
        ST_CSUM,
`endif
        ST_EOF
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   idx;
    logic [BUF_W-1:0]   buffer;
    logic               xfer;
`ifdef RESULT_FRAME_CSUM_EN
    logic [7:0]         csum;
`endif

    assign xfer = bus.tx_valid && bus.tx_ack;

    // Byte i of the frame payload: word i/BPW, most significant byte first.
    function automatic logic [7:0] byte_at(input logic [BUF_W-1:0] b,
                                           input logic [CNT_W-1:0] i);
        int unsigned      n;
        int unsigned      off;
        logic [BUF_W-1:0] s;
        n   = 32'(i);
        off = (n / BPW) * DATA_W + (BPW - 1 - (n % BPW)) * 8;
        s   = b >> off;
        return s[7:0];
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= ST_IDLE;
            idx            <= '0;
            buffer         <= '0;
            bus.res_ready  <= 1'b1;
            bus.tx_valid   <= 1'b0;
            bus.tx_data    <= 8'h00;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
`ifdef RESULT_FRAME_CSUM_EN
            csum           <= 8'h00;
`endif
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.res_valid && bus.res_ready) begin
                        buffer        <= bus.res_data;
                        state         <= ST_SOF;
                        bus.tx_valid  <= 1'b1;
                        bus.tx_data   <= SOF_BYTE;
                        bus.res_ready <= 1'b0;
                        bus.busy      <= 1'b1;
`ifdef RESULT_FRAME_CSUM_EN
                        csum          <= 8'h00;
`endif
                    end
                end
                ST_SOF: begin
                    if (xfer) begin
                        state       <= ST_PAYLOAD;
                        idx         <= '0;
                        bus.tx_data <= byte_at(buffer, '0);
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
`ifdef RESULT_FRAME_CSUM_EN
                        csum <= csum ^ bus.tx_data;
`endif
                        if (idx == LAST_IDX) begin
`ifdef RESULT_FRAME_CSUM_EN
                            // Include the byte leaving now; the accumulator lags by one transfer.
                            state       <= ST_CSUM;
                            bus.tx_data <= csum ^ bus.tx_data;
`else
                            state       <= ST_EOF;
                            bus.tx_data <= EOF_BYTE;
`endif
                        end else begin
                            idx         <= idx + 1'b1;
                            bus.tx_data <= byte_at(buffer, idx + 1'b1);
                        end
                    end
                end
`ifdef RESULT_FRAME_CSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        state       <= ST_EOF;
                        bus.tx_data <= EOF_BYTE;
                    end
                end
`endif
                ST_EOF: begin
                    if (xfer) begin
                        state          <= ST_IDLE;
                        bus.tx_valid   <= 1'b0;
                        bus.tx_data    <= 8'h00;
                        bus.busy       <= 1'b0;
                        bus.res_ready  <= 1'b1;
                        bus.frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_frame_tx.sv
// Directed bench for result_frame_tx; expects the checksum byte when RESULT_FRAME_CSUM_EN is defined.
module tb_result_frame_tx;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned NUM_RESULTS = 4;

`ifdef RESULT_FRAME_CSUM_EN
    localparam int unsigned FRAME_LEN = 11;
    typedef logic [7:0] frame_t [FRAME_LEN];
    localparam frame_t EXP_A = '{8'hFE, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h40, 8'hFF};
    localparam frame_t EXP_B = '{8'hFE, 8'h01, 8'h02, 8'h80, 8'h40, 8'h5A, 8'hA5, 8'h7E, 8'h81, 8'hC3, 8'hFF};
`else
    localparam int unsigned FRAME_LEN = 10;
    typedef logic [7:0] frame_t [FRAME_LEN];
    localparam frame_t EXP_A = '{8'hFE, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    localparam frame_t EXP_B = '{8'hFE, 8'h01, 8'h02, 8'h80, 8'h40, 8'h5A, 8'hA5, 8'h7E, 8'h81, 8'hFF};
`endif

    localparam logic [63:0] SET_A = {16'hFFFF, 16'h0000, 16'hABCD, 16'h1234};
    localparam logic [63:0] SET_B = {16'h7E81, 16'h5AA5, 16'h8040, 16'h0102};

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    result_frame_tx_if #(.DATA_W(DATA_W), .NUM_RESULTS(NUM_RESULTS)) bus ();

    result_frame_tx #(
        .DATA_W      (DATA_W),
        .NUM_RESULTS (NUM_RESULTS),
        .SOF_BYTE    (8'hFE),
        .EOF_BYTE    (8'hFF)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a result set for one edge; returns in the cycle after capture.
    task automatic capture(input logic [63:0] d);
        bus.res_data  = d;
        bus.res_valid = 1'b1;
        check("res_ready_idle", 32'(bus.res_ready), 32'd1);
        step();
        bus.res_valid = 1'b0;
    endtask

    // Starts in the SOF cycle, ends in the frame_done cycle.
    task automatic run_frame(input frame_t e, input int pct, input bit junk);
        int k   = 0;
        int cyc = 0;
        while (k < int'(FRAME_LEN) && cyc < 400) begin
            check("tx_valid", 32'(bus.tx_valid), 32'd1);
            check("tx_data", 32'(bus.tx_data), 32'(e[k]));
            check("busy", 32'(bus.busy), 32'd1);
            check("res_ready_busy", 32'(bus.res_ready), 32'd0);
            check("frame_done_mid", 32'(bus.frame_done), 32'd0);
            if (junk) begin
                bus.res_data  = '1;
                bus.res_valid = 1'($urandom_range(0, 1));
            end
            bus.tx_ack = (int'($urandom_range(0, 99)) < pct);
            if (bus.tx_ack) k++;
            cyc++;
            step();
        end
        check("frame_len", 32'(k), 32'(FRAME_LEN));
        if (junk) bus.res_valid = 1'b0;
        bus.tx_ack = 1'b0;
        check("frame_done", 32'(bus.frame_done), 32'd1);
        check("tx_valid_end", 32'(bus.tx_valid), 32'd0);
        check("res_ready_end", 32'(bus.res_ready), 32'd1);
        check("busy_end", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.res_data  = '0;
        bus.res_valid = 1'b0;
        bus.tx_ack    = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        check("rst_res_ready", 32'(bus.res_ready), 32'd1);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;
        step();

        // Single frame, ack always high
        capture(SET_A);
        run_frame(EXP_A, 100, 1'b0);
        step();
        check("frame_done_pulse", 32'(bus.frame_done), 32'd0);
        check("idle_tx_valid", 32'(bus.tx_valid), 32'd0);

        // Random backpressure
        capture(SET_A);
        run_frame(EXP_A, 30, 1'b0);
        step();

        // Upstream noise while busy must not touch the frame
        capture(SET_A);
        run_frame(EXP_A, 60, 1'b1);
        step();
        step();
        check("no_second_frame", 32'(bus.tx_valid), 32'd0);
        check("no_second_busy", 32'(bus.busy), 32'd0);

        // Back-to-back with res_valid held
        bus.res_data  = SET_A;
        bus.res_valid = 1'b1;
        step();
        bus.res_data  = SET_B;
        run_frame(EXP_A, 100, 1'b0);
        step();
        bus.res_valid = 1'b0;
        run_frame(EXP_B, 100, 1'b0);
        step();

        // Reset during the third payload byte
        capture(SET_B);
        bus.tx_ack = 1'b1;
        step();
        step();
        step();
        check("pre_reset_byte", 32'(bus.tx_data), 32'h80);
        bus.tx_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_res_ready", 32'(bus.res_ready), 32'd1);
        check("abort_tx_data", 32'(bus.tx_data), 32'h00);
        #3;
        rst_n = 1'b1;
        step();
        check("abort_no_done", 32'(bus.frame_done), 32'd0);
        check("abort_idle", 32'(bus.tx_valid), 32'd0);
        capture(SET_A);
        run_frame(EXP_A, 100, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
